adc_pipe_dec_corrector: RTL

- Parametrised digital error-correction and encoder back-end for the N-stage pipelined ADC, generalising the existing pipe encoder.
- Each cycle, every stage presents its sub-ADC code for a different sample; this block time-aligns the codes and performs the redundancy-overlap sum.
- Applies a signed digital offset, then clamps to the output range.
- Tracks sample validity, illegal stage codes and saturation events. Sits between the analog stage comparators and the core data output.

---
 rtl/adc_pipe_dec_corrector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/adc_pipe_dec_corrector.sv
`default_nettype none
// ============================================================================
// adc_pipe_dec_corrector : pipelined-ADC stage alignment, overlap sum, offset, clamp
// Revision: 1.0
// ============================================================================
module adc_pipe_dec_corrector #(
    parameter int NUM_STAGES     = 6,
    parameter int BITS_PER_STAGE = 2,
    parameter int REDUNDANCY     = 1,
    parameter int BITS_ADC_STAGE = 2,
    parameter int NUM_BITS       = NUM_STAGES*(BITS_PER_STAGE-REDUNDANCY)+BITS_ADC_STAGE,
    parameter int OFFSET_W       = 6,
    parameter int CNT_W          = 16
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 valid_i,
    input  logic [NUM_STAGES*BITS_PER_STAGE-1:0] d_stage_i,
    input  logic [BITS_ADC_STAGE-1:0]            d_last_stage_i,
    input  logic [OFFSET_W-1:0]                  offset_i,
    input  logic                                 clear_i,
    output logic [NUM_BITS-1:0]                  d_o,
    output logic                                 valid_o,
    output logic                                 ovf_o,
    output logic                                 unf_o,
    output logic                                 code_err_o,
    output logic [CNT_W-1:0]                     sat_count_o
);

    localparam int c_SUM_W = NUM_BITS + 2;
    localparam logic [BITS_PER_STAGE-1:0] c_ILLEGAL = '1;
    localparam logic [BITS_PER_STAGE-1:0] c_REPL    = BITS_PER_STAGE'((2**BITS_PER_STAGE)-2);
    localparam logic signed [c_SUM_W-1:0] c_MAX_CODE = c_SUM_W'((2**NUM_BITS)-1);

    function automatic int stage_shift(input int j);
        return (NUM_STAGES-1-j)*(BITS_PER_STAGE-REDUNDANCY) + BITS_ADC_STAGE - REDUNDANCY;
    endfunction

    logic [BITS_PER_STAGE-1:0] aligned [NUM_STAGES];
    logic [NUM_STAGES-1:0]     vtok_q;

    // Stage j is launched j cycles after stage 0, so it needs NUM_STAGES-j taps to line up.
    generate
        for (genvar j = 0; j < NUM_STAGES; j++) begin : g_stage
            localparam int c_DEPTH = NUM_STAGES - j;
            logic [BITS_PER_STAGE-1:0] line_q [c_DEPTH];

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int k = 0; k < c_DEPTH; k++) line_q[k] <= '0;
                end else begin
                    line_q[0] <= d_stage_i[j*BITS_PER_STAGE +: BITS_PER_STAGE];
                    for (int k = 1; k < c_DEPTH; k++) line_q[k] <= line_q[k-1];
                end
            end

            assign aligned[j] = line_q[c_DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            vtok_q <= '0;
        end else begin
            vtok_q[0] <= valid_i;
            for (int k = 1; k < NUM_STAGES; k++) vtok_q[k] <= vtok_q[k-1];
        end
    end

    logic signed [c_SUM_W-1:0] sum_d;
    logic                      err_d;
    logic [BITS_PER_STAGE-1:0] code_w;

    always_comb begin
        sum_d  = c_SUM_W'($signed(offset_i));
        sum_d  = sum_d + c_SUM_W'(d_last_stage_i);
        err_d  = 1'b0;
        code_w = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            code_w = aligned[j];
            if (REDUNDANCY >= 1 && code_w == c_ILLEGAL) begin
                code_w = c_REPL;
                err_d  = 1'b1;
            end
            sum_d = sum_d + (c_SUM_W'(code_w) << stage_shift(j));
        end
    end

    logic signed [c_SUM_W-1:0] sum_q;
    logic                      v1_q;
    logic                      err1_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q  <= '0;
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            v1_q   <= vtok_q[NUM_STAGES-1];
            err1_q <= err_d;
        end
    end

    logic [NUM_BITS-1:0] clamp_d;
    logic                ovf_d;
    logic                unf_d;
    logic [CNT_W-1:0]    cnt_d;

    always_comb begin
        clamp_d = sum_q[NUM_BITS-1:0];
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (sum_q[c_SUM_W-1]) begin
            clamp_d = '0;
            unf_d   = 1'b1;
        end else if (sum_q > c_MAX_CODE) begin
            clamp_d = '1;
            ovf_d   = 1'b1;
        end
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        cnt_d = sat_count_o;
        if (v1_q && (ovf_d || unf_d) && sat_count_o != '1) cnt_d = sat_count_o + 1'b1;
        if (clear_i) cnt_d = '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            d_o         <= '0;
            valid_o     <= 1'b0;
            ovf_o       <= 1'b0;
            unf_o       <= 1'b0;
            code_err_o  <= 1'b0;
            sat_count_o <= '0;
        end else begin
            valid_o     <= v1_q;
            ovf_o       <= v1_q & ovf_d;
            unf_o       <= v1_q & unf_d;
            code_err_o  <= v1_q & err1_q;
            sat_count_o <= cnt_d;
            if (v1_q) d_o <= clamp_d;
        end
    end

endmodule
`default_nettype wire
